// File: rtl/ast_fifo_fwft.sv
// ---------------------------------------------------------------------------
// ast_fifo_fwft
//   Single-clock streaming FIFO for AST producer/consumer stages.
//   Supports any DEPTH >= 2, occupancy count, programmable almost-full and
//   almost-empty flags, sticky overflow/underflow, synchronous flush, and
//   either a registered read port (FWFT=0) or first-word-fall-through (FWFT=1).
//
//   Optional build macro: FIFO_HWM_EN adds a high_water output that tracks the
//   maximum occupancy seen since the last reset or clr.
//
// Ports:
//   clk           clock, all state updates on the rising edge
//   rst_n         asynchronous active-low reset
//   clr           synchronous flush (priority over push/pop)
//   push          write request, data_in captured when accepted
//   pop           read request (FWFT=1: consume head word)
//   data_in       write data
//   data_out      read data (registered or fall-through, see FWFT)
//   empty, full   count == 0 / count == DEPTH
//   almost_empty  count <= AEMPTY_THRESH
//   almost_full   count >= AFULL_THRESH
//   count         occupancy
//   overflow      sticky: a push was rejected
//   underflow     sticky: a pop was rejected
//   high_water    (FIFO_HWM_EN only) maximum count since reset/clr
// ---------------------------------------------------------------------------
module ast_fifo_fwft #(
  parameter int DEPTH         = 8,
  parameter int DATAWIDTH     = 8,
  parameter int AFULL_THRESH  = 6,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0,
  localparam int CW           = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 push,
  input  logic                 pop,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic [DATAWIDTH-1:0] data_out,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_empty,
  output logic                 almost_full,
  output logic [CW-1:0]        count,
  output logic                 overflow,
  output logic                 underflow
`ifdef FIFO_HWM_EN
  , output logic [CW-1:0]      high_water
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Illegal configurations stop elaboration rather than being clamped.
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("ast_fifo_fwft: DEPTH must be >= 2");
    end
    if (DATAWIDTH < 1) begin : g_bad_width
      $error("ast_fifo_fwft: DATAWIDTH must be >= 1");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
      $error("ast_fifo_fwft: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
      $error("ast_fifo_fwft: AEMPTY_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
      $error("ast_fifo_fwft: FWFT must be 0 or 1");
    end
  endgenerate

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          empty_reg, full_reg, almost_empty_reg, almost_full_reg;
  logic          overflow_reg, underflow_reg;
  logic          push_ok, pop_ok;

  // Acceptance uses registered flags only. A push into a full FIFO is still
  // accepted when a pop frees a slot on the same edge; a pop from an empty
  // FIFO is always rejected, even alongside a push.
  always_comb begin
    pop_ok      = pop & ~empty_reg;
    push_ok     = push & (~full_reg | pop_ok);
    count_next  = count_reg + CW'(push_ok) - CW'(pop_ok);
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    // Explicit wrap so non-power-of-2 depths never index past DEPTH-1.
    if (push_ok) begin
      wr_ptr_next = (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else if (clr) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      empty_reg        <= 1'b1;
      full_reg         <= 1'b0;
      almost_empty_reg <= 1'b1;
      almost_full_reg  <= 1'b0;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      wr_ptr_reg       <= wr_ptr_next;
      rd_ptr_reg       <= rd_ptr_next;
      count_reg        <= count_next;
      // Flags come from the next count so they move on the same edge as count.
      empty_reg        <= (count_next == '0);
      full_reg         <= (count_next == CW'(DEPTH));
      almost_empty_reg <= (count_next <= CW'(AEMPTY_THRESH));
      almost_full_reg  <= (count_next >= CW'(AFULL_THRESH));
      if (push & ~push_ok) overflow_reg  <= 1'b1;
      if (pop & ~pop_ok)   underflow_reg <= 1'b1;
    end
  end

  // Storage is never reset; writes are suppressed during reset and flush.
  always_ff @(posedge clk) begin
    if (push_ok && !clr && rst_n) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word presented directly; forced to zero while empty.
      assign data_out = empty_reg ? '0 : mem[rd_ptr_reg];
    end else begin : g_regd
      logic [DATAWIDTH-1:0] data_out_reg;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_reg <= '0;
        end else if (clr) begin
          data_out_reg <= '0;
        end else if (pop_ok) begin
          data_out_reg <= mem[rd_ptr_reg];
        end
      end
      assign data_out = data_out_reg;
    end
  endgenerate

`ifdef FIFO_HWM_EN
  logic [CW-1:0] high_water_reg;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      high_water_reg <= '0;
    end else if (clr) begin
      high_water_reg <= '0;
    end else if (count_next > high_water_reg) begin
      high_water_reg <= count_next;
    end
  end
  assign high_water = high_water_reg;
`endif

  assign empty        = empty_reg;
  assign full         = full_reg;
  assign almost_empty = almost_empty_reg;
  assign almost_full  = almost_full_reg;
  assign count        = count_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_ast_fifo_fwft.sv
// ---------------------------------------------------------------------------
// tb_ast_fifo_fwft
//   Directed bench for ast_fifo_fwft. Three instances: DEPTH=8 registered
//   read (d8), DEPTH=5 registered read (d5), DEPTH=8 fall-through (df).
//   Stimulus pushes expected read data into per-instance queues; a monitor
//   samples the expectation strobe at the clock edge and compares data_out
//   half a cycle later. Status outputs are checked inline.
// ---------------------------------------------------------------------------
module tb_ast_fifo_fwft;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // d8: DEPTH 8, FWFT 0
  logic clr8 = 1'b0, push8 = 1'b0, pop8 = 1'b0;
  logic [7:0] din8 = '0, dout8;
  logic e8, f8, ae8, af8, ov8, un8;
  logic [3:0] c8;
  // d5: DEPTH 5, FWFT 0
  logic clr5 = 1'b0, push5 = 1'b0, pop5 = 1'b0;
  logic [7:0] din5 = '0, dout5;
  logic e5, f5, ae5, af5, ov5, un5;
  logic [2:0] c5;
  // df: DEPTH 8, FWFT 1
  logic clrf = 1'b0, pushf = 1'b0, popf = 1'b0;
  logic [7:0] dinf = '0, doutf;
  logic ef, ff, aef, aff, ovf, unf;
  logic [3:0] cf;
`ifdef FIFO_HWM_EN
  logic [3:0] hw8, hwf;
  logic [2:0] hw5;
`endif

  // Scoreboard: expectation strobes and queues of expected data_out.
  logic ev8 = 1'b0, ev5 = 1'b0, evf = 1'b0;
  logic [7:0] q8[$];
  logic [7:0] q5[$];
  logic [7:0] qf[$];

  ast_fifo_fwft #(.DEPTH(8), .DATAWIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(0)) u_d8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8), .push(push8), .pop(pop8), .data_in(din8),
    .data_out(dout8), .empty(e8), .full(f8), .almost_empty(ae8), .almost_full(af8),
    .count(c8), .overflow(ov8), .underflow(un8)
`ifdef FIFO_HWM_EN
    , .high_water(hw8)
`endif
  );

  ast_fifo_fwft #(.DEPTH(5), .DATAWIDTH(8), .AFULL_THRESH(4), .AEMPTY_THRESH(1), .FWFT(0)) u_d5 (
    .clk(clk), .rst_n(rst_n), .clr(clr5), .push(push5), .pop(pop5), .data_in(din5),
    .data_out(dout5), .empty(e5), .full(f5), .almost_empty(ae5), .almost_full(af5),
    .count(c5), .overflow(ov5), .underflow(un5)
`ifdef FIFO_HWM_EN
    , .high_water(hw5)
`endif
  );

  ast_fifo_fwft #(.DEPTH(8), .DATAWIDTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2), .FWFT(1)) u_df (
    .clk(clk), .rst_n(rst_n), .clr(clrf), .push(pushf), .pop(popf), .data_in(dinf),
    .data_out(doutf), .empty(ef), .full(ff), .almost_empty(aef), .almost_full(aff),
    .count(cf), .overflow(ovf), .underflow(unf)
`ifdef FIFO_HWM_EN
    , .high_water(hwf)
`endif
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic op8(input logic pu, input logic po, input logic [7:0] d,
                     input logic expv, input logic [7:0] expd);
    push8 = pu; pop8 = po; din8 = d; ev8 = expv;
    if (expv) q8.push_back(expd);
    @(negedge clk);
    push8 = 1'b0; pop8 = 1'b0; ev8 = 1'b0;
    $display("d8 push=%0b pop=%0b clr=%0b din=0x%02h -> count=%0d dout=0x%02h", pu, po, clr8, d, c8, dout8);
  endtask

  task automatic op5(input logic pu, input logic po, input logic [7:0] d,
                     input logic expv, input logic [7:0] expd);
    push5 = pu; pop5 = po; din5 = d; ev5 = expv;
    if (expv) q5.push_back(expd);
    @(negedge clk);
    push5 = 1'b0; pop5 = 1'b0; ev5 = 1'b0;
    $display("d5 push=%0b pop=%0b din=0x%02h -> count=%0d dout=0x%02h", pu, po, d, c5, dout5);
  endtask

  task automatic opf(input logic pu, input logic po, input logic [7:0] d,
                     input logic expv, input logic [7:0] expd);
    pushf = pu; popf = po; dinf = d; evf = expv;
    if (expv) qf.push_back(expd);
    @(negedge clk);
    pushf = 1'b0; popf = 1'b0; evf = 1'b0;
    $display("df push=%0b pop=%0b din=0x%02h -> count=%0d dout=0x%02h", pu, po, d, cf, doutf);
  endtask

  // Status of d8 for an expected occupancy n (AFULL 6, AEMPTY 2, DEPTH 8).
  task automatic flags8(input int n);
    chk("d8_count",  int'(c8),  n);
    chk("d8_empty",  int'(e8),  int'(n == 0));
    chk("d8_full",   int'(f8),  int'(n == 8));
    chk("d8_aempty", int'(ae8), int'(n <= 2));
    chk("d8_afull",  int'(af8), int'(n >= 6));
  endtask

  // Monitor: strobe sampled at the edge, data compared at the following negedge.
  initial begin
    logic s8, s5, sf;
    logic [7:0] e;
    forever begin
      @(posedge clk);
      s8 = ev8; s5 = ev5; sf = evf;
      @(negedge clk);
      if (s8) begin
        if (q8.size() == 0) chk("d8_sb_underrun", 1, 0);
        else begin e = q8.pop_front(); chk("d8_data", int'(dout8), int'(e)); end
      end
      if (s5) begin
        if (q5.size() == 0) chk("d5_sb_underrun", 1, 0);
        else begin e = q5.pop_front(); chk("d5_data", int'(dout5), int'(e)); end
      end
      if (sf) begin
        if (qf.size() == 0) chk("df_sb_underrun", 1, 0);
        else begin e = qf.pop_front(); chk("df_data", int'(doutf), int'(e)); end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    flags8(0);
    chk("d8_rst_ovf", int'(ov8), 0);
    chk("d8_rst_unf", int'(un8), 0);
    chk("d8_rst_dout", int'(dout8), 0);
    chk("d5_rst_empty", int'(e5), 1);
    chk("df_rst_empty", int'(ef), 1);
    chk("df_rst_dout", int'(doutf), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // d8 fill with threshold tracking
    for (int i = 1; i <= 8; i++) begin
      op8(1'b1, 1'b0, 8'(i), 1'b0, 8'h00);
      flags8(i);
    end
    // Full with push+pop: both accepted, no overflow
    op8(1'b1, 1'b1, 8'h09, 1'b1, 8'h01);
    flags8(8);
    chk("d8_fullpp_ovf", int'(ov8), 0);
    // Push into full: rejected, sticky overflow
    op8(1'b1, 1'b0, 8'hEE, 1'b0, 8'h00);
    flags8(8);
    chk("d8_ovf_set", int'(ov8), 1);
`ifdef FIFO_HWM_EN
    chk("d8_hw_full", int'(hw8), 8);
`endif
    // Drain with symmetric threshold reverts
    for (int i = 0; i < 8; i++) begin
      op8(1'b0, 1'b1, 8'h00, 1'b1, 8'(i + 2));
      flags8(7 - i);
    end
    chk("d8_drain_unf", int'(un8), 0);
    // Empty with push+pop: push taken, pop rejected
    op8(1'b1, 1'b1, 8'h55, 1'b0, 8'h00);
    flags8(1);
    chk("d8_emptypp_unf", int'(un8), 1);
    chk("d8_dout_hold", int'(dout8), 8'h09);
    op8(1'b0, 1'b1, 8'h00, 1'b1, 8'h55);
    flags8(0);
    // Flush with pending push
    for (int i = 0; i < 4; i++) op8(1'b1, 1'b0, 8'(8'h10 + i), 1'b0, 8'h00);
    flags8(4);
    chk("d8_preclr_ovf", int'(ov8), 1);
    clr8 = 1'b1;
    op8(1'b1, 1'b0, 8'h77, 1'b0, 8'h00);
    clr8 = 1'b0;
    flags8(0);
    chk("d8_clr_ovf", int'(ov8), 0);
    chk("d8_clr_unf", int'(un8), 0);
    chk("d8_clr_dout", int'(dout8), 0);
`ifdef FIFO_HWM_EN
    chk("d8_hw_clr", int'(hw8), 0);
`endif
    op8(1'b1, 1'b0, 8'hAB, 1'b0, 8'h00);
    op8(1'b0, 1'b1, 8'h00, 1'b1, 8'hAB);
    flags8(0);

    // d5: wrap with non-power-of-2 depth
    for (int i = 0; i < 3; i++) op5(1'b1, 1'b0, 8'(8'h11 + i), 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) op5(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'h11 + i));
    chk("d5_mid_count", int'(c5), 0);
    for (int i = 0; i < 5; i++) op5(1'b1, 1'b0, 8'(8'hA0 + i), 1'b0, 8'h00);
    chk("d5_count_full", int'(c5), 5);
    chk("d5_full", int'(f5), 1);
    chk("d5_afull", int'(af5), 1);
    op5(1'b1, 1'b0, 8'hFF, 1'b0, 8'h00);
    chk("d5_ovf", int'(ov5), 1);
    chk("d5_count_hold", int'(c5), 5);
    for (int i = 0; i < 5; i++) op5(1'b0, 1'b1, 8'h00, 1'b1, 8'(8'hA0 + i));
    chk("d5_empty", int'(e5), 1);
    chk("d5_count_end", int'(c5), 0);

    // df: fall-through
    opf(1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C);
    chk("df_empty_after_push", int'(ef), 0);
    chk("df_count1", int'(cf), 1);
    opf(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    chk("df_empty_after_pop", int'(ef), 1);
    opf(1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A);
    opf(1'b1, 1'b0, 8'h6B, 1'b1, 8'h5A);
    opf(1'b0, 1'b1, 8'h00, 1'b1, 8'h6B);
    opf(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    opf(1'b1, 1'b1, 8'h77, 1'b1, 8'h77);
    chk("df_emptypp_unf", int'(unf), 1);
    chk("df_emptypp_count", int'(cf), 1);
    opf(1'b0, 1'b1, 8'h00, 1'b1, 8'h00);
    opf(1'b1, 1'b0, 8'h99, 1'b1, 8'h99);

    // Asynchronous reset mid-cycle while pushing
    op8(1'b1, 1'b0, 8'hC1, 1'b0, 8'h00);
    op8(1'b1, 1'b0, 8'hC2, 1'b0, 8'h00);
    flags8(2);
    push8 = 1'b1; din8 = 8'h42;
    #2 rst_n = 1'b0;
    #1;
    flags8(0);
    chk("d8_async_dout", int'(dout8), 0);
    chk("df_async_dout", int'(doutf), 0);
    chk("df_async_empty", int'(ef), 1);
    chk("df_async_unf", int'(unf), 0);
    @(negedge clk);
    push8 = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    flags8(0);

    repeat (2) @(negedge clk);
    chk("sb_drained", q8.size() + q5.size() + qf.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
